// File: rtl/caxi4interconnect_fifo_downsizing_if.sv
// Bus interface for caxi4interconnect_fifo_downsizing.
// Carries the wide write side, the narrow read side and the occupancy flags.
// Optional macro CAXI4_FIFO_DOWNSIZING_LAST_EN adds data_out_last.
interface caxi4interconnect_fifo_downsizing_if #(
    parameter int DATA_WIDTH_IN    = 128,
    parameter int DATA_WIDTH_OUT   = 32,
    parameter int EXTRA_DATA_WIDTH = 8
);
    localparam int RATIO = DATA_WIDTH_IN / DATA_WIDTH_OUT;
    localparam int SW    = $clog2(RATIO);

    logic                                       wr_en;
    logic [DATA_WIDTH_IN+EXTRA_DATA_WIDTH-1:0]  data_in;
    logic [SW-1:0]                              wr_first_slice;
    logic [SW-1:0]                              wr_last_slice;
    logic                                       rd_en;
    logic [DATA_WIDTH_OUT+EXTRA_DATA_WIDTH-1:0] data_out;
    logic                                       data_out_valid;
    logic [SW-1:0]                              data_out_slice;
    logic                                       fifo_full;
    logic                                       fifo_empty;
    logic                                       fifo_nearly_full;
    logic                                       fifo_nearly_empty;
    logic                                       fifo_one_from_full;
`ifdef CAXI4_FIFO_DOWNSIZING_LAST_EN
    logic                                       data_out_last;
`endif

    // FIFO side: consumes writes and read strobes, drives data and flags
    modport slave (
`ifdef CAXI4_FIFO_DOWNSIZING_LAST_EN
        output data_out_last,
`endif
        input  wr_en, data_in, wr_first_slice, wr_last_slice, rd_en,
        output data_out, data_out_valid, data_out_slice,
        output fifo_full, fifo_empty, fifo_nearly_full, fifo_nearly_empty, fifo_one_from_full
    );

    // User side: produces writes and read strobes, observes data and flags
    modport master (
`ifdef CAXI4_FIFO_DOWNSIZING_LAST_EN
        input  data_out_last,
`endif
        output wr_en, data_in, wr_first_slice, wr_last_slice, rd_en,
        input  data_out, data_out_valid, data_out_slice,
        input  fifo_full, fifo_empty, fifo_nearly_full, fifo_nearly_empty, fifo_one_from_full
    );
endinterface

// File: rtl/caxi4interconnect_fifo_downsizing.sv
// Wide-to-narrow buffering FIFO for the AXI4 data-width converters.
// Wide entries are stored in a RAM; one entry at a time sits in a registered
// head and is presented slice by slice from its first to its last index.
// The storage count excludes the head entry.
// Optional macro CAXI4_FIFO_DOWNSIZING_LAST_EN adds data_out_last, which flags
// the final slice of the head entry.
module caxi4interconnect_fifo_downsizing #(
    parameter int MEM_DEPTH           = 16,
    parameter int DATA_WIDTH_IN       = 128,
    parameter int DATA_WIDTH_OUT      = 32,
    parameter int EXTRA_DATA_WIDTH    = 8,
    parameter int NEARLY_FULL_THRESH  = 12,
    parameter int NEARLY_EMPTY_THRESH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    caxi4interconnect_fifo_downsizing_if.slave    bus
);
    localparam int DEPTH = (MEM_DEPTH < 4) ? 4 : MEM_DEPTH;
    localparam int RATIO = DATA_WIDTH_IN / DATA_WIDTH_OUT;
    localparam int SW    = $clog2(RATIO);
    localparam int W     = DATA_WIDTH_IN + EXTRA_DATA_WIDTH;
    localparam int EW    = W + 2 * SW;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    // Storage entry layout: {last, first, extra, data}
    logic [EW-1:0]             r_mem [DEPTH];
    logic [AW-1:0]             r_wrPtr;
    logic [AW-1:0]             r_rdPtr;
    logic [CW-1:0]             r_count;
    logic                      r_headValid;
    logic [W-1:0]              r_headData;
    logic [SW-1:0]             r_headLast;
    logic [SW-1:0]             r_slice;
    logic                      r_full;
    logic                      r_empty;
    logic                      r_nearlyFull;
    logic                      r_nearlyEmpty;
    logic                      r_oneFromFull;

    logic [EW-1:0]             w_memEntry;
    logic                      w_wrAccept;
    logic                      w_sliceRead;
    logic                      w_lastConsume;
    logic                      w_headLoad;
    logic                      w_headValidNext;
    logic [CW-1:0]             w_countNext;
    logic [DATA_WIDTH_OUT-1:0] w_sliceData;

    function automatic logic [AW-1:0] incPtr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_memEntry      = r_mem[r_rdPtr];
    assign w_wrAccept      = bus.wr_en && !r_full;
    assign w_sliceRead     = r_headValid && bus.rd_en;
    assign w_lastConsume   = w_sliceRead && (r_slice == r_headLast);
    // The head refills either when idle or in the same cycle its last slice leaves,
    // which is what keeps back-to-back entries free of bubbles.
    assign w_headLoad      = (r_count != '0) && (!r_headValid || w_lastConsume);
    assign w_headValidNext = w_headLoad || (r_headValid && !w_lastConsume);

    // Next storage count: a write and a head load in the same cycle cancel out
    always_comb begin
        w_countNext = r_count;
        if (w_wrAccept && !w_headLoad) begin
            w_countNext = r_count + CW'(1);
        end else if (!w_wrAccept && w_headLoad) begin
            w_countNext = r_count - CW'(1);
        end
    end

    // Select the slice of the head entry addressed by the slice pointer
    always_comb begin
        w_sliceData = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (r_slice == SW'(i)) begin
                w_sliceData = r_headData[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
            end
        end
    end

    // Storage RAM write port, no reset so it can map onto memory
    always_ff @(posedge clk) begin
        if (w_wrAccept) begin
            r_mem[r_wrPtr] <= {bus.wr_last_slice, bus.wr_first_slice, bus.data_in};
        end
    end

    // Pointers, count, head entry, slice pointer and registered flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_count       <= '0;
            r_headValid   <= 1'b0;
            r_headData    <= '0;
            r_headLast    <= '0;
            r_slice       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_nearlyFull  <= 1'b0;
            r_nearlyEmpty <= 1'b1;
            r_oneFromFull <= 1'b0;
        end else begin
            if (w_wrAccept) begin
                r_wrPtr <= incPtr(r_wrPtr);
            end
            if (w_headLoad) begin
                r_rdPtr    <= incPtr(r_rdPtr);
                r_headData <= w_memEntry[W-1:0];
                r_slice    <= w_memEntry[W +: SW];
                r_headLast <= w_memEntry[W+SW +: SW];
            end else if (w_lastConsume) begin
                r_headData <= '0;
                r_slice    <= '0;
                r_headLast <= '0;
            end else if (w_sliceRead) begin
                r_slice <= r_slice + SW'(1);
            end
            r_headValid   <= w_headValidNext;
            r_count       <= w_countNext;
            r_full        <= (w_countNext == CW'(DEPTH));
            r_oneFromFull <= (w_countNext == CW'(DEPTH - 1));
            r_nearlyFull  <= (int'(w_countNext) >= NEARLY_FULL_THRESH);
            r_nearlyEmpty <= (int'(w_countNext) <= NEARLY_EMPTY_THRESH);
            r_empty       <= (w_countNext == '0) && !w_headValidNext;
        end
    end

    generate
        if (EXTRA_DATA_WIDTH > 0) begin : g_extra
            assign bus.data_out = {r_headData[DATA_WIDTH_IN +: EXTRA_DATA_WIDTH], w_sliceData};
        end else begin : g_noExtra
            assign bus.data_out = w_sliceData;
        end
    endgenerate

    assign bus.data_out_valid     = r_headValid;
    assign bus.data_out_slice     = r_slice;
    assign bus.fifo_full          = r_full;
    assign bus.fifo_empty         = r_empty;
    assign bus.fifo_nearly_full   = r_nearlyFull;
    assign bus.fifo_nearly_empty  = r_nearlyEmpty;
    assign bus.fifo_one_from_full = r_oneFromFull;
`ifdef CAXI4_FIFO_DOWNSIZING_LAST_EN
    assign bus.data_out_last      = r_headValid && (r_slice == r_headLast);
`endif
endmodule

// File: tb/tb_caxi4interconnect_fifo_downsizing.sv
// Testbench for caxi4interconnect_fifo_downsizing at default parameters.
// A queue-based reference model tracks storage and the head entry and is
// compared against the DUT on every falling edge; directed scenarios pin
// the model with hand-computed values before a randomized phase.
module tb_caxi4interconnect_fifo_downsizing;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nTotal = 0;
    int   nBad   = 0;
    bit   checkEn = 1'b0;

    typedef struct {
        logic [135:0] data;
        logic [1:0]   first;
        logic [1:0]   last;
    } entryT;

    entryT      mStore[$];
    entryT      mHead;
    logic       mValid;
    logic [1:0] mSlice;

    caxi4interconnect_fifo_downsizing_if #(
        .DATA_WIDTH_IN(128), .DATA_WIDTH_OUT(32), .EXTRA_DATA_WIDTH(8)
    ) bus ();

    caxi4interconnect_fifo_downsizing #(
        .MEM_DEPTH(16), .DATA_WIDTH_IN(128), .DATA_WIDTH_OUT(32), .EXTRA_DATA_WIDTH(8),
        .NEARLY_FULL_THRESH(12), .NEARLY_EMPTY_THRESH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTotal++;
        if (act !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and return at the next falling edge
    task automatic applyStimulus(input logic wr, input logic [135:0] d, input logic [1:0] f,
                                 input logic [1:0] l, input logic rd);
        bus.wr_en          = wr;
        bus.data_in        = d;
        bus.wr_first_slice = f;
        bus.wr_last_slice  = l;
        bus.rd_en          = rd;
        @(negedge clk);
    endtask

    function automatic logic [135:0] randData();
        return {8'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [39:0] sliceOf(input logic [135:0] d, input logic [1:0] s);
        logic [127:0] sh;
        sh = d[127:0] >> (32 * s);
        return {d[135:128], sh[31:0]};
    endfunction

    // Reference model: storage queue plus one head entry, updated at each rising edge
    initial begin
        bit acc;
        bit lastC;
        bit load;
        int sz;
        mValid = 1'b0;
        mSlice = 2'd0;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mStore.delete();
                mValid = 1'b0;
                mSlice = 2'd0;
            end else begin
                sz    = mStore.size();
                acc   = bus.wr_en && (sz < DEPTH);
                lastC = mValid && bus.rd_en && (mSlice == mHead.last);
                load  = (sz > 0) && (!mValid || lastC);
                if (load) begin
                    mHead  = mStore.pop_front();
                    mSlice = mHead.first;
                    mValid = 1'b1;
                end else if (lastC) begin
                    mValid = 1'b0;
                end else if (mValid && bus.rd_en) begin
                    mSlice = mSlice + 2'd1;
                end
                if (acc) begin
                    mStore.push_back('{data: bus.data_in, first: bus.wr_first_slice,
                                       last: bus.wr_last_slice});
                end
            end
        end
    end

    // Compare DUT outputs against the model away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (checkEn) begin
                checkOutput("valid", 64'(bus.data_out_valid), 64'(mValid));
                if (mValid) begin
                    checkOutput("data", 64'(bus.data_out), 64'(sliceOf(mHead.data, mSlice)));
                    checkOutput("slice", 64'(bus.data_out_slice), 64'(mSlice));
                end
`ifdef CAXI4_FIFO_DOWNSIZING_LAST_EN
                checkOutput("last", 64'(bus.data_out_last), 64'(mValid && (mSlice == mHead.last)));
`endif
                checkOutput("full", 64'(bus.fifo_full), 64'(mStore.size() == DEPTH));
                checkOutput("empty", 64'(bus.fifo_empty), 64'(mStore.size() == 0 && !mValid));
                checkOutput("nearly_full", 64'(bus.fifo_nearly_full), 64'(mStore.size() >= 12));
                checkOutput("nearly_empty", 64'(bus.fifo_nearly_empty), 64'(mStore.size() <= 2));
                checkOutput("one_from_full", 64'(bus.fifo_one_from_full), 64'(mStore.size() == DEPTH - 1));
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, " valid"}, 64'(bus.data_out_valid), 64'd0);
        checkOutput({tag, " data"}, 64'(bus.data_out), 64'd0);
        checkOutput({tag, " slice"}, 64'(bus.data_out_slice), 64'd0);
        checkOutput({tag, " empty"}, 64'(bus.fifo_empty), 64'd1);
        checkOutput({tag, " nearly_empty"}, 64'(bus.fifo_nearly_empty), 64'd1);
        checkOutput({tag, " full"}, 64'(bus.fifo_full), 64'd0);
        checkOutput({tag, " nearly_full"}, 64'(bus.fifo_nearly_full), 64'd0);
        checkOutput({tag, " one_from_full"}, 64'(bus.fifo_one_from_full), 64'd0);
`ifdef CAXI4_FIFO_DOWNSIZING_LAST_EN
        checkOutput({tag, " last"}, 64'(bus.data_out_last), 64'd0);
`endif
    endtask

    initial begin
        logic [135:0] d1;
        logic [135:0] d;
        logic [135:0] fillData[18];
        logic [1:0]   fillSlice[18];
        logic [1:0]   sliceQ[$];
        logic [39:0]  dataQ[$];
        int           validCnt;
        int           run;
        int           maxRun;
        int           pw;
        int           pr;

        bus.wr_en = 1'b0; bus.data_in = '0; bus.wr_first_slice = '0;
        bus.wr_last_slice = '0; bus.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b1;
        checkEn = 1'b1;

        // Single full entry: valid appears after the second rising edge counting the write edge
        d1 = {8'hA5, 128'h44443333_22221111_00000000_FFFFFFFF};
        applyStimulus(1'b1, d1, 2'd0, 2'd3, 1'b1);
        checkOutput("t1 valid after write edge", 64'(bus.data_out_valid), 64'd0);
        applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b1);
        checkOutput("t1 valid after load edge", 64'(bus.data_out_valid), 64'd1);
        checkOutput("t1 slice0", 64'(bus.data_out), 64'hA5_FFFFFFFF);
        checkOutput("t1 slice0 idx", 64'(bus.data_out_slice), 64'd0);
        applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b1);
        checkOutput("t1 slice1", 64'(bus.data_out), 64'hA5_00000000);
        applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b1);
        checkOutput("t1 slice2", 64'(bus.data_out), 64'hA5_22221111);
        applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b1);
        checkOutput("t1 slice3", 64'(bus.data_out), 64'hA5_44443333);
        applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b1);
        checkOutput("t1 valid after retire", 64'(bus.data_out_valid), 64'd0);
        checkOutput("t1 empty after retire", 64'(bus.fifo_empty), 64'd1);

        // Wrapping entry first=3, last=1 gives slices 3,0,1
        d = randData();
        applyStimulus(1'b1, d, 2'd3, 2'd1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b1);
            if (bus.data_out_valid) begin
                sliceQ.push_back(bus.data_out_slice);
                dataQ.push_back(bus.data_out);
            end
        end
        checkOutput("t2 slice count", 64'(sliceQ.size()), 64'd3);
        if (sliceQ.size() == 3) begin
            checkOutput("t2 seq0", 64'(sliceQ[0]), 64'd3);
            checkOutput("t2 seq1", 64'(sliceQ[1]), 64'd0);
            checkOutput("t2 seq2", 64'(sliceQ[2]), 64'd1);
            checkOutput("t2 data0", 64'(dataQ[0]), 64'({d[135:128], d[127:96]}));
            checkOutput("t2 data1", 64'(dataQ[1]), 64'({d[135:128], d[31:0]}));
            checkOutput("t2 data2", 64'(dataQ[2]), 64'({d[135:128], d[63:32]}));
        end

        // Single slice entry first=last=2
        d = randData();
        applyStimulus(1'b1, d, 2'd2, 2'd2, 1'b1);
        applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b1);
        checkOutput("t3 valid", 64'(bus.data_out_valid), 64'd1);
        checkOutput("t3 data", 64'(bus.data_out), 64'({d[135:128], d[95:64]}));
        checkOutput("t3 slice", 64'(bus.data_out_slice), 64'd2);
        applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b1);
        checkOutput("t3 retired", 64'(bus.data_out_valid), 64'd0);

        // Fill with 18 writes and no reads; the 18th is dropped
        for (int k = 0; k < 18; k++) begin
            fillData[k]  = randData();
            fillSlice[k] = 2'(k);
            applyStimulus(1'b1, fillData[k], fillSlice[k], fillSlice[k], 1'b0);
            if (k == 11) checkOutput("t4 nearly_full at 11", 64'(bus.fifo_nearly_full), 64'd0);
            if (k == 12) checkOutput("t4 nearly_full at 12", 64'(bus.fifo_nearly_full), 64'd1);
            if (k == 14) checkOutput("t4 one_from_full at 14", 64'(bus.fifo_one_from_full), 64'd0);
            if (k == 15) begin
                checkOutput("t4 one_from_full at 15", 64'(bus.fifo_one_from_full), 64'd1);
                checkOutput("t4 full at 15", 64'(bus.fifo_full), 64'd0);
            end
            if (k == 16) checkOutput("t4 full at 16", 64'(bus.fifo_full), 64'd1);
            if (k == 17) checkOutput("t4 full after drop", 64'(bus.fifo_full), 64'd1);
        end
        dataQ.delete();
        for (int i = 0; i < 40; i++) begin
            if (bus.data_out_valid) dataQ.push_back(bus.data_out);
            applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b1);
        end
        checkOutput("t4 drained entries", 64'(dataQ.size()), 64'd17);
        if (dataQ.size() == 17) begin
            for (int k = 0; k < 17; k++) begin
                checkOutput("t4 drain order", 64'(dataQ[k]), 64'(sliceOf(fillData[k], fillSlice[k])));
            end
        end

        // Back-to-back two-slice entries keep valid high for 8 cycles
        validCnt = 0; run = 0; maxRun = 0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(i < 4, randData(), 2'd0, 2'd1, 1'b1);
            if (bus.data_out_valid) begin
                validCnt++;
                run++;
                if (run > maxRun) maxRun = run;
            end else begin
                run = 0;
            end
        end
        checkOutput("t5 valid cycles", 64'(validCnt), 64'd8);
        checkOutput("t5 longest run", 64'(maxRun), 64'd8);

        // Reset in the middle of an entry after two of four slices are read
        d = randData();
        applyStimulus(1'b1, d, 2'd0, 2'd3, 1'b0);
        applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b0);
        applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b1);
        applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b1);
        bus.rd_en = 1'b0;
        checkOutput("t6 slice before reset", 64'(bus.data_out_slice), 64'd2);
        checkEn = 1'b0;
        #2 rst = 1'b0;
        #1 checkResetState("t6 mid reset");
        @(negedge clk);
        rst = 1'b1;
        checkEn = 1'b1;
        d = randData();
        applyStimulus(1'b1, d, 2'd1, 2'd2, 1'b1);
        applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b1);
        checkOutput("t6 post reset valid", 64'(bus.data_out_valid), 64'd1);
        checkOutput("t6 post reset slice", 64'(bus.data_out_slice), 64'd1);
        checkOutput("t6 post reset data", 64'(bus.data_out), 64'({d[135:128], d[63:32]}));
        repeat (3) applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b1);

        // Randomized traffic in phases of differing pressure
        for (int ph = 0; ph < 3; ph++) begin
            pw = (ph == 0) ? 90 : ((ph == 1) ? 30 : 60);
            pr = (ph == 0) ? 25 : ((ph == 1) ? 90 : 60);
            for (int i = 0; i < 1000; i++) begin
                applyStimulus($urandom_range(0, 99) < pw, randData(),
                              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                              $urandom_range(0, 99) < pr);
            end
        end
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, '0, 2'd0, 2'd0, 1'b1);
        end
        checkOutput("final empty", 64'(bus.fifo_empty), 64'd1);

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end
endmodule
